// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache request sequencer: FSM state
// encoding, op-bit meanings and index-width helpers.
package cache_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_OP,
    ST_LOAD_RA,
    ST_LOAD_WA,
    ST_LOAD_WD,
    ST_LOADED,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DONE
  } state_t;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits when DEPTH is 1.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_LOAD_OP: return ST_LOAD_RA;
      ST_LOAD_RA: return ST_LOAD_WA;
      ST_LOAD_WA: return ST_LOAD_WD;
      default:    return ST_LOADED;
    endcase
  endfunction

endpackage

// File: rtl/seq_load_buffer.sv
// DEPTH x DW register file: one synchronous write port, one asynchronous
// read port, cleared by the synchronous reset.
module seq_load_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  localparam int IW   = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cache_req_sequencer.sv
// Loads a request program serially (op, read addr, write addr, write data),
// then issues it to one cache port with one request outstanding at a time.
module cache_req_sequencer
  import cache_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        store,
  input  logic                        start,
  input  logic [DW-1:0]               input_data,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic                        req_we,
  output logic [DW-1:0]               req_addr,
  output logic [DW-1:0]               req_wdata,
  input  logic                        rsp_valid,
  input  logic                        rsp_hit,
  input  logic [DW-1:0]               rsp_rdata,
  input  logic [idx_w(DEPTH)-1:0]     res_idx,
  output logic [DW-1:0]               res_rdata,
  output logic [clog2(DEPTH+1)-1:0]   hit_count,
  output logic                        loaded,
  output logic                        busy,
  output logic                        done,
  output logic                        start_err
);

  localparam int IW = idx_w(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  state_t           state;
  logic [IW-1:0]    index;
  logic [DEPTH-1:0] op_vec;

  logic          in_load;
  logic          restart;
  logic          do_start;
  logic          last_entry;
  logic [IW-1:0] iss_idx;
  logic [DW-1:0] ra_rd;
  logic [DW-1:0] wa_rd;
  logic [DW-1:0] wd_rd;
  logic          nxt_read;
  logic          ra_we;
  logic          wa_we;
  logic          wd_we;
  logic          res_we;

  assign in_load    = (state == ST_LOAD_OP) || (state == ST_LOAD_RA) ||
                      (state == ST_LOAD_WA) || (state == ST_LOAD_WD);
  // start wins over store in LOADED; store wins over start in DONE.
  assign do_start   = start && ((state == ST_LOADED) || ((state == ST_DONE) && !store));
  assign restart    = store && ((state == ST_IDLE) || (state == ST_DONE) ||
                                ((state == ST_LOADED) && !start));
  assign last_entry = (index == LAST);

  // Buffers are read at the entry about to be issued so the request
  // fields can be registered on the transition into ISSUE.
  assign iss_idx  = (state == ST_WAIT_RSP) ? index + 1'b1 : '0;
  assign nxt_read = (op_vec[iss_idx] == OP_READ);

  assign ra_we  = store && (state == ST_LOAD_RA);
  assign wa_we  = store && (state == ST_LOAD_WA);
  assign wd_we  = store && (state == ST_LOAD_WD);
  assign res_we = (state == ST_WAIT_RSP) && rsp_valid && (op_vec[index] == OP_READ);

  seq_load_buffer #(.DEPTH(DEPTH), .DW(DW)) u_ra (
    .clk(clk), .rst(rst), .we(ra_we), .waddr(index), .wdata(input_data),
    .raddr(iss_idx), .rdata(ra_rd)
  );

  seq_load_buffer #(.DEPTH(DEPTH), .DW(DW)) u_wa (
    .clk(clk), .rst(rst), .we(wa_we), .waddr(index), .wdata(input_data),
    .raddr(iss_idx), .rdata(wa_rd)
  );

  seq_load_buffer #(.DEPTH(DEPTH), .DW(DW)) u_wd (
    .clk(clk), .rst(rst), .we(wd_we), .waddr(index), .wdata(input_data),
    .raddr(iss_idx), .rdata(wd_rd)
  );

  seq_load_buffer #(.DEPTH(DEPTH), .DW(DW)) u_res (
    .clk(clk), .rst(rst), .we(res_we), .waddr(index), .wdata(rsp_rdata),
    .raddr(res_idx), .rdata(res_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      op_vec    <= '0;
      hit_count <= '0;
      start_err <= 1'b0;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      loaded    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (in_load && start) start_err <= 1'b1;

      case (state)
        ST_IDLE, ST_LOADED, ST_DONE: begin
          if (do_start) begin
            state     <= ST_ISSUE;
            index     <= '0;
            hit_count <= '0;
            req_valid <= 1'b1;
            req_we    <= ~nxt_read;
            req_addr  <= nxt_read ? ra_rd : wa_rd;
            req_wdata <= nxt_read ? '0 : wd_rd;
            busy      <= 1'b1;
            loaded    <= 1'b0;
            done      <= 1'b0;
          end else if (restart) begin
            op_vec[0] <= input_data[0];
            loaded    <= 1'b0;
            done      <= 1'b0;
            if (DEPTH == 1) begin
              state <= ST_LOAD_RA;
              index <= '0;
            end else begin
              state <= ST_LOAD_OP;
              index <= IW'(1);
            end
          end
        end

        ST_LOAD_OP, ST_LOAD_RA, ST_LOAD_WA, ST_LOAD_WD: begin
          if (store) begin
            if (state == ST_LOAD_OP) op_vec[index] <= input_data[0];
            if (last_entry) begin
              index  <= '0;
              state  <= next_phase(state);
              loaded <= (state == ST_LOAD_WD);
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          if (req_ready) begin
            state     <= ST_WAIT_RSP;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
          end
        end

        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_hit) hit_count <= hit_count + 1'b1;
            if (last_entry) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index     <= index + 1'b1;
              state     <= ST_ISSUE;
              req_valid <= 1'b1;
              req_we    <= ~nxt_read;
              req_addr  <= nxt_read ? ra_rd : wa_rd;
              req_wdata <= nxt_read ? '0 : wd_rd;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Directed-plus-random bench for cache_req_sequencer against a behavioural
// model of the loaded program, the request stream and the result buffer.
module tb_cache_req_sequencer;
  localparam int DEPTH = 2;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst, store, start;
  logic [DW-1:0] input_data;
  logic          req_valid, req_ready, req_we;
  logic [DW-1:0] req_addr, req_wdata;
  logic          rsp_valid, rsp_hit;
  logic [DW-1:0] rsp_rdata;
  logic [0:0]    res_idx;
  logic [DW-1:0] res_rdata;
  logic [1:0]    hit_count;
  logic          loaded, busy, done, start_err;

  cache_req_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .store(store), .start(start), .input_data(input_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata), .res_idx(res_idx),
    .res_rdata(res_rdata), .hit_count(hit_count), .loaded(loaded),
    .busy(busy), .done(done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the program as loaded, the responses to return and
  // the expected result buffer contents.
  bit            m_op  [DEPTH];
  logic [DW-1:0] m_ra  [DEPTH];
  logic [DW-1:0] m_wa  [DEPTH];
  logic [DW-1:0] m_wd  [DEPTH];
  logic [DW-1:0] m_res [DEPTH];
  bit            rh    [DEPTH];
  logic [DW-1:0] rr    [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; store = 1'b0; start = 1'b0; input_data = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0; rsp_rdata = '0; res_idx = '0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) m_res[k] = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_valid"}, req_valid, 0);
    chk({tag, "_req_we"}, req_we, 0);
    chk({tag, "_req_addr"}, req_addr, 0);
    chk({tag, "_req_wdata"}, req_wdata, 0);
    chk({tag, "_hit_count"}, hit_count, 0);
    chk({tag, "_loaded"}, loaded, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_start_err"}, start_err, 0);
    for (int k = 0; k < DEPTH; k++) begin
      res_idx = k[0:0];
      #1;
      chk({tag, "_res_rdata"}, res_rdata, 0);
    end
  endtask

  task automatic randomize_model();
    for (int k = 0; k < DEPTH; k++) begin
      m_op[k] = 1'($urandom);
      m_ra[k] = DW'($urandom);
      m_wa[k] = DW'($urandom);
      m_wd[k] = DW'($urandom);
    end
  endtask

  // Streams the model program; optional 2-cycle store gap before word
  // gap_at, and a start pulse alongside word err_at.
  task automatic load(input int gap_at, input int err_at);
    logic [DW-1:0] w;
    for (int n = 0; n < 4 * DEPTH; n++) begin
      if (n == gap_at) begin
        store = 1'b0;
        repeat (2) tick();
        chk("gap_loaded", loaded, 0);
      end
      case (n / DEPTH)
        0: begin w = DW'($urandom); w[0] = m_op[n % DEPTH]; end
        1: w = m_ra[n % DEPTH];
        2: w = m_wa[n % DEPTH];
        default: w = m_wd[n % DEPTH];
      endcase
      store = 1'b1;
      input_data = w;
      start = (n == err_at);
      tick();
      start = 1'b0;
    end
    store = 1'b0;
    chk("load_loaded", loaded, 1);
    chk("load_busy", busy, 0);
  endtask

  // Runs the loaded program; rdy_dly < 0 picks random ready stalls,
  // rand_rsp selects random responses instead of rh/rr.
  task automatic run(input int rdy_dly, input bit rand_rsp);
    int hits, n, d;
    bit exp_we;
    logic [DW-1:0] exp_addr, exp_wd, rd;
    bit hit;
    hits = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_req_valid", req_valid, 1);
    chk("start_hit_count", hit_count, 0);
    for (int i = 0; i < DEPTH; i++) begin
      n = 0;
      while (req_valid !== 1'b1 && n < 8) begin tick(); n++; end
      chk("req_valid_wait", req_valid, 1);
      exp_we   = !m_op[i];
      exp_addr = m_op[i] ? m_ra[i] : m_wa[i];
      exp_wd   = m_op[i] ? '0 : m_wd[i];
      chk("req_we", req_we, exp_we);
      chk("req_addr", req_addr, exp_addr);
      chk("req_wdata", req_wdata, exp_wd);
      chk("busy", busy, 1);
      d = (rdy_dly < 0) ? int'($urandom_range(0, 3)) : rdy_dly;
      repeat (d) begin
        rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_rdata = DW'($urandom);
        store = 1'($urandom); start = 1'($urandom);
        tick();
        chk("stall_valid", req_valid, 1);
        chk("stall_we", req_we, exp_we);
        chk("stall_addr", req_addr, exp_addr);
        chk("stall_wdata", req_wdata, exp_wd);
      end
      rsp_valid = 1'b0; store = 1'b0; start = 1'b0;
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk("wait_req_valid", req_valid, 0);
      repeat ($urandom_range(0, 2)) tick();
      hit = rand_rsp ? 1'($urandom) : rh[i];
      rd  = rand_rsp ? DW'($urandom) : rr[i];
      rsp_valid = 1'b1; rsp_hit = hit; rsp_rdata = rd;
      tick();
      rsp_valid = 1'b0;
      if (hit) hits++;
      if (m_op[i]) m_res[i] = rd;
      if (i < DEPTH - 1) chk("next_req_valid", req_valid, 1);
    end
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_hit_count", hit_count, hits);
    for (int k = 0; k < DEPTH; k++) begin
      res_idx = k[0:0];
      #1;
      chk("run_res_rdata", res_rdata, m_res[k]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check_idle_outputs("reset");

    // start in IDLE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_start_busy", busy, 0);
    chk("idle_start_err", start_err, 0);

    // Two reads, all hits
    m_op = '{1, 1}; m_ra = '{8'd12, 8'd1}; m_wa = '{8'd23, 8'd79}; m_wd = '{8'd1, 8'd3};
    rh = '{1, 1}; rr = '{8'hAA, 8'hBB};
    load(-1, -1);
    run(0, 1'b0);

    // Write then read, ready stalled 3 cycles, one miss
    m_op = '{0, 1};
    rh = '{0, 1}; rr = '{8'h55, 8'h66};
    load(-1, -1);
    run(3, 1'b0);

    // store gap after the last read address
    randomize_model();
    load(2 * DEPTH, -1);
    run(-1, 1'b1);

    // start pulsed during LOAD_WA
    randomize_model();
    load(-1, 2 * DEPTH);
    chk("start_err_set", start_err, 1);
    run(-1, 1'b1);
    chk("start_err_sticky", start_err, 1);

    // Rerun from DONE with the same buffers, then reload from DONE
    run(-1, 1'b1);
    for (int r = 0; r < 4; r++) begin
      randomize_model();
      load((r == 1) ? 3 : -1, -1);
      run(-1, 1'b1);
    end

    // Reset while waiting for the response of entry 1
    randomize_model();
    load(-1, -1);
    start = 1'b1; tick(); start = 1'b0;
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_rdata = 8'h3C; tick(); rsp_valid = 1'b0;
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) m_res[k] = '0;
    check_idle_outputs("midrun_rst");
    rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_rdata = 8'hE7; tick(); rsp_valid = 1'b0;
    check_idle_outputs("post_rst_rsp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_req_sequencer.md
Name: cache_req_sequencer

Overview:
- Sits directly upstream of one cache controller port; two instances are used, one per cache port.
- Captures a serial load stream from input_data while store is high. The stream is loaded in four phases of DEPTH entries each: op, read address, write address, write data.
- On start, issues the captured requests to the cache in order, one outstanding request at a time.
- Records each response's hit and read data, and counts hits.

Parameters:
DEPTH, 2, number of request entries per load phase and per run
DW, 8, width of input_data, addresses and data

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
store  in  1  load enable; one input_data word is captured per cycle while high
start  in  1  begins the issue sequence when sampled high in LOADED
input_data  in  DW  serial load word
req_valid  out  1  request to the cache is valid
req_ready  in  1  cache accepts the request this cycle
req_we  out  1  1 = write, 0 = read
req_addr  out  DW  request address
req_wdata  out  DW  write data; 0 on reads
rsp_valid  in  1  cache response valid
rsp_hit  in  1  response hit flag
rsp_rdata  in  DW  response read data
res_idx  in  clog2(DEPTH)  result buffer select
res_rdata  out  DW  combinational read of result buffer entry res_idx
hit_count  out  clog2(DEPTH+1)  number of hits in the current run
loaded  out  1  high in LOADED
busy  out  1  high in ISSUE and WAIT_RSP
done  out  1  high in DONE
start_err  out  1  sticky; set when start is sampled high in LOAD_*

Behaviour:
- States: IDLE, LOAD_OP, LOAD_RA, LOAD_WA, LOAD_WD, LOADED, ISSUE, WAIT_RSP, DONE.
- Reset (rst high at a clock edge):
  - state = IDLE; index = 0.
  - All outputs 0, including hit_count and start_err.
  - All buffers (op, read address, write address, write data, result) cleared to 0.
  - Reset applies in any state and aborts a load or issue in progress.
- IDLE: store=1 captures input_data[0] into op[0]; index = 1; next state LOAD_OP, or LOAD_RA when DEPTH=1.
- LOAD_* phases:
  - Each cycle with store=1 writes input_data into the current phase buffer at index, then increments index.
  - Op entries store input_data[0]: 1 = read, 0 = write.
  - When index reaches DEPTH, index returns to 0 and the next phase begins.
  - Completing LOAD_WD moves to LOADED.
  - store=0 holds state and index; the load resumes when store returns high.
- LOADED:
  - start=1 takes priority over store: go to ISSUE with index = 0 and hit_count = 0.
  - Otherwise store=1 restarts the load; it behaves as in IDLE.
- ISSUE: req_valid=1. Request fields for entry index:
  - req_we = ~op[index].
  - req_addr = read address[index] when op[index]=1, else write address[index].
  - req_wdata = write data[index] on writes, 0 on reads.
  - The request stays stable until the cycle where req_ready=1; that cycle completes the handshake and the next state is WAIT_RSP.
- WAIT_RSP: req_valid=0. On rsp_valid=1:
  - Result buffer entry index = rsp_rdata on reads, unchanged on writes.
  - hit_count increments when rsp_hit=1.
  - If index = DEPTH-1, go to DONE; else increment index and return to ISSUE.
- First req_valid is asserted the cycle after start is sampled. Minimum of 2 cycles per entry.
- DONE:
  - hit_count and the result buffer hold.
  - store=1 restarts the load (as in IDLE); start=1 alone re-runs from ISSUE with the same buffers.
- Ignored inputs:
  - rsp_valid outside WAIT_RSP.
  - store and start during ISSUE and WAIT_RSP.
  - start in IDLE.
- start=1 in any LOAD_* state sets start_err; the load continues unaffected. start_err is cleared only by rst.
- Arithmetic:
  - hit_count cannot overflow: at most DEPTH hits per run.
  - index wraps only at phase boundaries, never modulo 2^width.

Decomposition:
- Shared package cache_pkg:
  - State enum.
  - OP_READ=1 and OP_WRITE=0 constants.
  - Index width function clog2.
- One natural sub-module: seq_load_buffer, a DEPTH x DW register file with a sync write port and an async read port. Instantiated for read address, write address, write data and results; op uses a DEPTH-bit vector.

Test Plan:
- Load ops 1,1, read addresses 12,1, write addresses 23,79, write data 1,3; then start=1, cache always ready, responses hit=1 with rdata 0xAA, 0xBB → requests (we=0, addr=12) then (we=0, addr=1); hit_count=2; results [0xAA, 0xBB]; done=1.
- Ops 0,1 with the same addresses and data, with req_ready held low 3 cycles on entry 0 → req (we=1, addr=23, wdata=1) held stable 4 cycles; then (we=0, addr=1); hit_count counts only rsp_hit=1 responses.
- store dropped for 2 cycles after the second read address → phase and index hold; the loaded contents match an uninterrupted load.
- start pulsed during LOAD_WA → start_err=1 stays high; the load completes to LOADED; a later start issues normally.
- rst asserted in WAIT_RSP of entry 1 → next cycle: all outputs 0, state IDLE; a subsequent rsp_valid is ignored.
- In DONE: pulse start → identical request sequence reissued, hit_count restarts at 0. Then store=1 → load restarts at op[0].
